// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with count, thresholds and sticky errors
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     w_in,
  input  logic                     r_in,
  output logic                     w_full,
  output logic                     w_almost_full,
  output logic                     r_empty,
  output logic                     r_almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         data_out,
  output logic                     r_valid,
  output logic                     w_overflow,
  output logic                     r_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow_q;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Flags decode only the registered count, so w_in/r_in never reach them combinationally.
  assign w_full         = (r_count == CW'(DEPTH));
  assign r_empty        = (r_count == '0);
  assign w_almost_full  = (r_count >= CW'(AF_LEVEL));
  assign r_almost_empty = (r_count <= CW'(AE_LEVEL));
  assign count          = r_count;
  assign w_overflow     = r_overflow;
  assign r_underflow    = r_underflow_q;

  assign w_wr_acc = w_in && !w_full;
  assign w_rd_acc = r_in && !r_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_underflow_q <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_in && w_full)  r_overflow    <= 1'b1;
      if (r_in && r_empty) r_underflow_q <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown as soon as it exists; r_in pops what is already displayed.
  assign data_out = r_empty ? '0 : r_mem[r_rd_ptr];
  assign r_valid  = !r_empty;
`else
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out <= '0;
      r_valid_q  <= 1'b0;
    end else begin
      r_valid_q <= w_rd_acc;
      if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign data_out = r_data_out;
  assign r_valid  = r_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       w_in = 1'b0;
  logic       r_in = 1'b0;
  logic       w_full, w_almost_full, r_empty, r_almost_empty;
  logic [4:0] count;
  logic [7:0] data_out;
  logic       r_valid, w_overflow, r_underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .w_in(w_in), .r_in(r_in),
    .w_full(w_full), .w_almost_full(w_almost_full), .r_empty(r_empty),
    .r_almost_empty(r_almost_empty), .count(count), .data_out(data_out),
    .r_valid(r_valid), .w_overflow(w_overflow), .r_underflow(r_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    w_in = 1'b0; r_in = 1'b0; rst = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    logic [6:0] flags;
    rst = 1'b0; w_in = 1'b0; r_in = 1'b0;
    #2;
    flags = {r_empty, w_full, r_almost_empty, w_almost_full, r_valid, w_overflow, r_underflow};
    total++; if (flags !== 7'b1010000) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 7'b1010000); end
    total++; if (count !== 5'd0 || data_out !== 8'h00) begin bad++; $display("FAIL reset_count_data got=%0d/%h exp=0/00", count, data_out); end
    tick;
    rst = 1'b1;
    tick;
    flags = {r_empty, w_full, r_almost_empty, w_almost_full, r_valid, w_overflow, r_underflow};
    total++; if (flags !== 7'b1010000) begin bad++; $display("FAIL release_flags got=%b exp=%b", flags, 7'b1010000); end
    r_in = 1'b1;
    tick;
    r_in = 1'b0;
    total++; if (r_underflow !== 1'b1 || count !== 5'd0 || r_valid !== 1'b0) begin
      bad++; $display("FAIL empty_read got=uf%b cnt%0d v%b exp=uf1 cnt0 v0", r_underflow, count, r_valid); end
  endtask

  task automatic test_fill(output logic [7:0] pat [16]);
    for (int i = 0; i < 16; i++) pat[i] = 8'((i * 37 + 11) & 8'hFF);
    do_reset;
    for (int i = 0; i < 16; i++) begin
      data_in = pat[i]; w_in = 1'b1;
      tick;
      total++; if (count !== 5'(i + 1) || w_almost_full !== (i + 1 >= 14) || w_full !== (i == 15)) begin
        bad++; $display("FAIL fill_%0d got=cnt%0d af%b f%b exp=cnt%0d af%b f%b", i, count, w_almost_full, w_full, i + 1, (i + 1 >= 14), (i == 15)); end
    end
    data_in = 8'hEE;
    tick;
    w_in = 1'b0;
    total++; if (w_overflow !== 1'b1 || count !== 5'd16 || w_full !== 1'b1) begin
      bad++; $display("FAIL overflow got=ov%b cnt%0d exp=ov1 cnt16", w_overflow, count); end
  endtask

  task automatic test_drain(input logic [7:0] pat [16]);
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      total++; if (data_out !== pat[i] || r_valid !== 1'b1) begin
        bad++; $display("FAIL fwft_head_%0d got=%h v%b exp=%h v1", i, data_out, r_valid, pat[i]); end
`endif
      r_in = 1'b1;
      tick;
`ifndef FIFO_FWFT_EN
      total++; if (data_out !== pat[i] || r_valid !== 1'b1) begin
        bad++; $display("FAIL drain_data_%0d got=%h v%b exp=%h v1", i, data_out, r_valid, pat[i]); end
`endif
      total++; if (count !== 5'(15 - i) || r_empty !== (i == 15) || r_almost_empty !== ((15 - i) <= 2)) begin
        bad++; $display("FAIL drain_flags_%0d got=cnt%0d e%b ae%b exp=cnt%0d e%b ae%b", i, count, r_empty, r_almost_empty, 15 - i, (i == 15), ((15 - i) <= 2)); end
    end
    r_in = 1'b0;
    tick;
`ifdef FIFO_FWFT_EN
    total++; if (r_valid !== 1'b0 || data_out !== 8'h00) begin bad++; $display("FAIL idle_after_drain got=v%b %h exp=v0 00", r_valid, data_out); end
`else
    total++; if (r_valid !== 1'b0 || data_out !== pat[15]) begin bad++; $display("FAIL idle_after_drain got=v%b %h exp=v0 %h", r_valid, data_out, pat[15]); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] q [$];
    logic [7:0] exp;
    int errs = 0;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(8'h50 + i); w_in = 1'b1; q.push_back(data_in);
      tick;
    end
    for (int j = 0; j < 40; j++) begin
      data_in = 8'(8'h80 + j); w_in = 1'b1; r_in = 1'b1;
      exp = q.pop_front();
`ifdef FIFO_FWFT_EN
      if (data_out !== exp) begin errs++; $display("FAIL b2b_head_%0d got=%h exp=%h", j, data_out, exp); end
`endif
      tick;
      q.push_back(data_in);
`ifndef FIFO_FWFT_EN
      if (data_out !== exp || r_valid !== 1'b1) begin errs++; $display("FAIL b2b_data_%0d got=%h v%b exp=%h v1", j, data_out, r_valid, exp); end
`endif
      if (count !== 5'd5) begin errs++; $display("FAIL b2b_count_%0d got=%0d exp=5", j, count); end
    end
    w_in = 1'b0; r_in = 1'b0;
    total++; if (errs != 0) bad++;
    total++; if (w_overflow !== 1'b0 || r_underflow !== 1'b0) begin
      bad++; $display("FAIL b2b_errflags got=ov%b uf%b exp=ov0 uf0", w_overflow, r_underflow); end
  endtask

  task automatic test_full_both;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(i + 1); w_in = 1'b1;
      tick;
    end
    data_in = 8'hFF; r_in = 1'b1;
    tick;
    w_in = 1'b0; r_in = 1'b0;
    total++; if (count !== 5'd15 || w_overflow !== 1'b1 || w_full !== 1'b0) begin
      bad++; $display("FAIL full_both got=cnt%0d ov%b f%b exp=cnt15 ov1 f0", count, w_overflow, w_full); end
`ifndef FIFO_FWFT_EN
    total++; if (data_out !== 8'h01 || r_valid !== 1'b1) begin bad++; $display("FAIL full_both_data got=%h v%b exp=01 v1", data_out, r_valid); end
`else
    total++; if (data_out !== 8'h02 || r_valid !== 1'b1) begin bad++; $display("FAIL full_both_head got=%h v%b exp=02 v1", data_out, r_valid); end
`endif
  endtask

  task automatic test_empty_both;
    do_reset;
    data_in = 8'h3C; w_in = 1'b1; r_in = 1'b1;
    tick;
    w_in = 1'b0; r_in = 1'b0;
    total++; if (count !== 5'd1 || r_underflow !== 1'b1 || w_overflow !== 1'b0) begin
      bad++; $display("FAIL empty_both got=cnt%0d uf%b ov%b exp=cnt1 uf1 ov0", count, r_underflow, w_overflow); end
`ifdef FIFO_FWFT_EN
    total++; if (data_out !== 8'h3C || r_valid !== 1'b1) begin bad++; $display("FAIL empty_both_head got=%h v%b exp=3c v1", data_out, r_valid); end
`else
    total++; if (r_valid !== 1'b0 || data_out !== 8'h00) begin bad++; $display("FAIL empty_both_nodata got=%h v%b exp=00 v0", data_out, r_valid); end
    r_in = 1'b1;
    tick;
    r_in = 1'b0;
    total++; if (data_out !== 8'h3C || r_valid !== 1'b1) begin bad++; $display("FAIL empty_both_read got=%h v%b exp=3c v1", data_out, r_valid); end
`endif
  endtask

  task automatic test_async_reset;
    logic [6:0] flags;
    do_reset;
    r_in = 1'b1;
    tick;
    r_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      data_in = 8'(8'hC0 + i); w_in = 1'b1;
      tick;
    end
    w_in = 1'b0;
    total++; if (count !== 5'd9 || r_underflow !== 1'b1) begin bad++; $display("FAIL pre_reset got=cnt%0d uf%b exp=cnt9 uf1", count, r_underflow); end
    #2 rst = 1'b0;
    #1;
    flags = {r_empty, w_full, r_almost_empty, w_almost_full, r_valid, w_overflow, r_underflow};
    total++; if (count !== 5'd0 || flags !== 7'b1010000 || data_out !== 8'h00) begin
      bad++; $display("FAIL async_reset got=cnt%0d %b %h exp=cnt0 1010000 00", count, flags, data_out); end
    #1 rst = 1'b1;
    tick;
    data_in = 8'hA5; w_in = 1'b1;
    tick;
    w_in = 1'b0;
`ifdef FIFO_FWFT_EN
    total++; if (data_out !== 8'hA5 || r_valid !== 1'b1) begin bad++; $display("FAIL post_reset_word got=%h v%b exp=a5 v1", data_out, r_valid); end
`else
    r_in = 1'b1;
    tick;
    r_in = 1'b0;
    total++; if (data_out !== 8'hA5 || r_valid !== 1'b1) begin bad++; $display("FAIL post_reset_word got=%h v%b exp=a5 v1", data_out, r_valid); end
`endif
    total++; if (count !== 5'(0) && count !== 5'(1)) begin bad++; $display("FAIL post_reset_count got=%0d exp=0or1", count); end
  endtask

  initial begin
    logic [7:0] pat [16];
    test_reset;
    test_fill(pat);
    test_drain(pat);
    test_back_to_back;
    test_full_both;
    test_empty_both;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the single-domain successor to the team's dual-clock FIFO and buffers data between producer and consumer logic that share one clock. An optional first-word-fall-through read mode is selected at compile time.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of words; power of two, >=4
- AF_LEVEL, DEPTH-2, w_almost_full asserts when count >= AF_LEVEL (1..DEPTH-1)
- AE_LEVEL, 2, r_almost_empty asserts when count <= AE_LEVEL (1..DEPTH-1)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-low
- data_in  input  WIDTH  write data
- w_in  input  1  write request
- r_in  input  1  read request
- w_full  output  1  FIFO holds DEPTH words
- w_almost_full  output  1  count >= AF_LEVEL
- r_empty  output  1  FIFO holds 0 words
- r_almost_empty  output  1  count <= AE_LEVEL
- count  output  $clog2(DEPTH)+1  words currently stored
- data_out  output  WIDTH  read data
- r_valid  output  1  data_out carries a valid popped/head word
- w_overflow  output  1  sticky: write attempted while full
- r_underflow  output  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH array, not reset. Write/read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Write accepted iff w_in && !w_full: mem[wr_ptr] <= data_in, wr_ptr increments.
- Read accepted iff r_in && !r_empty: rd_ptr increments.
- count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
- When full, w_in && r_in: read accepted, write rejected, w_overflow sets. When empty, w_in && r_in: write accepted, read rejected, r_underflow sets.
- w_overflow sets on any cycle with w_in && w_full; r_underflow sets on r_in && r_empty; both clear only on reset.
- w_full, r_empty, w_almost_full, r_almost_empty are pure decodes of the registered count.
- Reset values: count 0, r_empty 1, w_full 0, r_almost_empty 1, w_almost_full 0, data_out 0, r_valid 0, w_overflow 0, r_underflow 0, pointers 0. Reset asserted mid-operation discards all content immediately.

## Timing
- All flags and count update in the cycle after the accepting edge; no combinational path from w_in/r_in to any flag.
- Standard mode: on accepted read at edge k, data_out <= mem[rd_ptr] at edge k; r_valid high for the one cycle after edge k. data_out holds its value when no read is accepted.
- Write-to-read latency (standard): write at edge k, r_empty low after k, earliest read accept at k+1, data at data_out and r_valid after k+1.
- Back-to-back reads sustain one word per cycle; r_valid stays high continuously.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through. data_out = mem[rd_ptr] combinationally whenever !r_empty, else 0; r_valid = !r_empty; r_in acknowledges/pops the displayed word. Word written at edge k is visible on data_out after edge k.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as above.
- Flags, count, and error behaviour identical in both modes.

## Test plan
- Reset release, WIDTH=8, DEPTH=16: all outputs at reset values; r_in for 1 cycle -> r_underflow=1, count stays 0.
- Write 16 random words -> count=16, w_full=1, w_almost_full=1 from count 14; 17th write -> w_overflow=1, content unchanged.
- Read 16 words -> data_out matches write order, r_valid one cycle after each read (standard), r_empty=1 at count 0, r_almost_empty=1 at count<=2.
- Simultaneous w_in/r_in at count 5 for 40 cycles -> count remains 5, pointers wrap past 15 twice, data order preserved.
- Full plus simultaneous w_in/r_in -> count 15, w_overflow=1; empty plus both -> count 1, r_underflow=1.
- Reset asserted with count=9 mid-stream -> count 0, r_empty=1 and flags cleared asynchronously; FWFT build: first write 0xA5 appears on data_out after that edge with r_valid=1.
